// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode encodings, baud table, oversampling
// divisor helper and the receiver state encoding.
package uart_pkg;

  localparam logic [1:0] PAR_ODD   = 2'b11;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_MARK  = 2'b01;
  localparam logic [1:0] PAR_SPACE = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // Baud rate selected by the 3-bit baud_sel code.
  function automatic int unsigned baud_rate(input logic [2:0] sel);
    case (sel)
      3'd0:    return 9600;
      3'd1:    return 19200;
      3'd2:    return 38400;
      3'd3:    return 57600;
      3'd4:    return 115200;
      3'd5:    return 230400;
      3'd6:    return 460800;
      default: return 921600;
    endcase
  endfunction

  // Clocks per 16x oversampling tick, rounded to nearest, never below 1.
  function automatic logic [15:0] ovs_div(input int unsigned clk_hz, input logic [2:0] sel);
    int unsigned b;
    int unsigned d;
    b = baud_rate(sel);
    d = (clk_hz + 8 * b) / (16 * b);
    if (d == 0) d = 1;
    if (d > 65535) d = 65535;
    return d[15:0];
  endfunction

endpackage

// File: rtl/uart_rx_tickgen.sv
// 16x oversampling tick generator. restart realigns the tick phase to a
// detected start edge so every frame samples at the same bit offsets.
module uart_rx_tickgen (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic [15:0] div,
  output logic        tick
);

  logic [15:0] cnt;

  assign tick = ~restart && (cnt == div - 16'd1);

  // Divisor counter: wraps on tick, forced to 0 on restart.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 16'd0;
    end else if (restart || tick) begin
      cnt <= 16'd0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 7/8 data bits LSB first, optional parity,
// 1 or 2 stop bits, one-cycle valid strobe with per-frame error flags.
// Handshake: valid is a one-cycle strobe with no ready; data and the error
// flags are updated in the same cycle and hold until the next strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] baud_sel,
  input  logic       data_size,
  input  logic       parity_en,
  input  logic [1:0] parity_mode,
  input  logic       stop_bit_size,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_error,
  output logic       frame_error,
  output logic       busy
);

  rx_state_t state;
  rx_state_t state_next;

  logic       rx_meta;
  logic       rx_sync;
  logic       rx_prev;
  logic       fall;

  logic [2:0] baud_q;
  logic       size_q;
  logic       par_en_q;
  logic [1:0] par_mode_q;
  logic       stop_q;

  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       par_flag;
  logic       frm_flag;

  logic [15:0] div;
  logic        tick;
  logic        start_go;
  logic        mid_start;
  logic        mid_bit;
  logic [2:0]  last_data;
  logic [2:0]  last_stop;
  logic        par_exp;

  assign fall      = rx_prev & ~rx_sync;
  assign start_go  = (state == ST_IDLE) && en && fall;
  assign mid_start = tick && (tick_cnt == 4'd7);
  assign mid_bit   = tick && (tick_cnt == 4'd15);
  assign last_data = size_q ? 3'd7 : 3'd6;
  assign last_stop = {2'b00, stop_q};

  // Two-stage synchronizer plus edge register, all idle-high out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Divisor for the baud rate latched at the start edge.
  always_comb begin
    div = ovs_div(CLK_HZ, 3'd7);
    case (baud_q)
      3'd0:    div = ovs_div(CLK_HZ, 3'd0);
      3'd1:    div = ovs_div(CLK_HZ, 3'd1);
      3'd2:    div = ovs_div(CLK_HZ, 3'd2);
      3'd3:    div = ovs_div(CLK_HZ, 3'd3);
      3'd4:    div = ovs_div(CLK_HZ, 3'd4);
      3'd5:    div = ovs_div(CLK_HZ, 3'd5);
      3'd6:    div = ovs_div(CLK_HZ, 3'd6);
      default: div = ovs_div(CLK_HZ, 3'd7);
    endcase
  end

  uart_rx_tickgen u_tickgen (
    .clk     (clk),
    .rst     (rst),
    .restart (start_go),
    .div     (div),
    .tick    (tick)
  );

  // Expected parity bit over the received data bits only.
  always_comb begin
    par_exp = 1'b0;
    case (par_mode_q)
      PAR_ODD:   par_exp = ~^shift;
      PAR_EVEN:  par_exp = ^shift;
      PAR_MARK:  par_exp = 1'b1;
      default:   par_exp = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state logic; en low overrides everything and aborts the frame.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start_go) state_next = ST_START;
      ST_START:  if (mid_start) state_next = rx_sync ? ST_IDLE : ST_DATA;
      ST_DATA:   if (mid_bit && (bit_cnt == last_data))
                   state_next = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: if (mid_bit) state_next = ST_STOP;
      ST_STOP:   if (mid_bit && (bit_cnt == last_stop)) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    if (!en) state_next = ST_IDLE;
  end

  // Datapath: config latch, counters, shift register, flags and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_q       <= 3'd0;
      size_q       <= 1'b0;
      par_en_q     <= 1'b0;
      par_mode_q   <= 2'b00;
      stop_q       <= 1'b0;
      tick_cnt     <= 4'd0;
      bit_cnt      <= 3'd0;
      shift        <= 8'd0;
      par_flag     <= 1'b0;
      frm_flag     <= 1'b0;
      data         <= 8'd0;
      valid        <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!en) begin
        busy <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (fall) begin
              baud_q     <= baud_sel;
              size_q     <= data_size;
              par_en_q   <= parity_en;
              par_mode_q <= parity_mode;
              stop_q     <= stop_bit_size;
              tick_cnt   <= 4'd0;
              bit_cnt    <= 3'd0;
              shift      <= 8'd0;
              par_flag   <= 1'b0;
              frm_flag   <= 1'b0;
            end
          end
          ST_START: begin
            if (tick) begin
              if (tick_cnt == 4'd7) begin
                tick_cnt <= 4'd0;
                if (!rx_sync) busy <= 1'b1;
              end else begin
                tick_cnt <= tick_cnt + 4'd1;
              end
            end
          end
          ST_DATA: begin
            if (tick) begin
              tick_cnt <= tick_cnt + 4'd1;
              if (tick_cnt == 4'd15) begin
                shift[bit_cnt] <= rx_sync;
                bit_cnt <= (bit_cnt == last_data) ? 3'd0 : bit_cnt + 3'd1;
              end
            end
          end
          ST_PARITY: begin
            if (tick) begin
              tick_cnt <= tick_cnt + 4'd1;
              if (tick_cnt == 4'd15) par_flag <= (rx_sync != par_exp);
            end
          end
          ST_STOP: begin
            if (tick) begin
              tick_cnt <= tick_cnt + 4'd1;
              if (tick_cnt == 4'd15) begin
                if (!rx_sync) frm_flag <= 1'b1;
                if (bit_cnt == last_stop) begin
                  data         <= shift;
                  parity_error <= par_flag;
                  frame_error  <= frm_flag | ~rx_sync;
                  valid        <= 1'b1;
                  busy         <= 1'b0;
                end else begin
                  bit_cnt <= bit_cnt + 3'd1;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
